// File: rtl/output_port_scheduler_pkg.sv
// Shared definitions for the switch output-port datapath: word layout,
// port count and scheduler state encoding.
package output_port_scheduler_pkg;

    localparam int WORD_W    = 33;
    localparam int EOP_BIT   = 32;
    localparam int NUM_PORTS = 4;
    localparam int PTR_W     = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/output_port_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester after rr_ptr, wrapping
// modulo NUM_PORTS. Shared by every output port of the switch.
module rr_arbiter
    import output_port_scheduler_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     rr_ptr,
    output logic [PTR_W-1:0]     grant,
    output logic                 any_req
);

    logic found;

    always_comb begin
        // NOTE: every variable gets a default before the search so no path leaves it unassigned (no latch).
        grant = rr_ptr;
        found = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (!found && req[rr_ptr + PTR_W'(k)]) begin
                grant = rr_ptr + PTR_W'(k);
                found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/output_port_scheduler.sv
// Output-port scheduler: round-robin packet arbitration over NUM_Q show-ahead
// queues, popping into a single registered valid/ready output stage.
module output_port_scheduler #(
    parameter int NUM_Q         = 4,
    parameter int WORD_W        = 33,
    parameter int MAX_PKT_WORDS = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_Q-1:0]         q_empty,
    input  logic [NUM_Q*WORD_W-1:0]  q_rd_data,
    output logic [NUM_Q-1:0]         q_rd_en,
    output logic [WORD_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               grant,
    output logic                     busy,
    output logic                     err_trunc
);
    import output_port_scheduler_pkg::*;

    localparam int                CNT_W    = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_PKT_WORDS - 1);

    state_t             state;
    logic [1:0]         rr_ptr;
    logic [CNT_W-1:0]   word_cnt;
    logic [1:0]         arb_grant;
    logic               any_req;
    logic               pop;
    logic [WORD_W-1:0]  head;

    rr_arbiter u_arb (
        .req     (~q_empty),
        .rr_ptr  (rr_ptr),
        .grant   (arb_grant),
        .any_req (any_req)
    );

    assign head    = q_rd_data[grant*WORD_W +: WORD_W];
    // Pop only when the output register is free or draining this same cycle.
    assign pop     = (state == BUSY) && !q_empty[grant] && (!out_valid || out_ready);
    assign q_rd_en = pop ? (NUM_Q'(1) << grant) : '0;
    assign busy    = (state == BUSY);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 2'd3;
            grant     <= 2'd0;
            word_cnt  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            err_trunc <= 1'b0;
        end else begin
            err_trunc <= 1'b0;
            if (out_valid && out_ready && !pop) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant  <= arb_grant;
                        rr_ptr <= arb_grant;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (pop) begin
                        out_data  <= head;
                        out_valid <= 1'b1;
                        if (head[EOP_BIT]) begin
                            state    <= IDLE;
                            word_cnt <= '0;
                        end else if (word_cnt == CNT_LAST) begin
                            // Runaway packet: abort; its tail is re-arbitrated as a new packet.
                            state     <= IDLE;
                            err_trunc <= 1'b1;
                            word_cnt  <= '0;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_port_scheduler.sv
// Directed bench for output_port_scheduler: behavioural show-ahead queues,
// a per-cycle vector table for one packet, and hand sequences for corner cases.
module tb_output_port_scheduler;

    localparam int NQ   = 4;
    localparam int WW   = 33;
    localparam int MAXW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NQ-1:0]     q_empty;
    logic [NQ*WW-1:0]  q_rd_data;
    logic [NQ-1:0]     q_rd_en;
    logic [WW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        grant;
    logic              busy;
    logic              err_trunc;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [WW-1:0] qm [NQ][$];
    logic [WW-1:0] out_log[$];
    logic [WW-1:0] exp_out[$];
    logic [1:0]    grant_log[$];
    int            pop_log[$];

    typedef struct {
        logic          ready;
        logic [3:0]    rd_en;
        logic          ov;
        logic          chk_od;
        logic [WW-1:0] od;
        logic [1:0]    gnt;
        logic          bsy;
    } vec_t;

    vec_t vecs[6];

    output_port_scheduler #(
        .NUM_Q         (NQ),
        .WORD_W        (WW),
        .MAX_PKT_WORDS (MAXW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .q_empty   (q_empty),
        .q_rd_data (q_rd_data),
        .q_rd_en   (q_rd_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy),
        .err_trunc (err_trunc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NQ; i++) begin
            q_empty[i] = (qm[i].size() == 0);
            q_rd_data[i*WW +: WW] = (qm[i].size() == 0) ? '0 : qm[i][0];
        end
    endtask

    // One clock: sample DUT before the edge, update the queue model after it.
    task automatic step();
        logic [3:0]    en;
        logic          r, ov, rdy, b, ok;
        logic [WW-1:0] od;
        logic [1:0]    g;
        en  = q_rd_en;
        r   = rst;
        ov  = out_valid;
        rdy = out_ready;
        od  = out_data;
        b   = busy;
        g   = grant;
        if (!r && en != 4'b0000) begin
            ok = $onehot(en) && en[g] && (qm[g].size() != 0);
            check("rd_en_legal", {63'd0, ok}, 64'd1);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            for (int i = 0; i < NQ; i++) qm[i].delete();
        end else begin
            for (int i = 0; i < NQ; i++) begin
                if (en[i] && qm[i].size() != 0) begin
                    void'(qm[i].pop_front());
                    pop_log.push_back(cyc);
                end
            end
            if (ov && rdy) out_log.push_back(od);
        end
        if (!b && busy) grant_log.push_back(grant);
        refresh();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_logs();
        out_log.delete();
        exp_out.delete();
        grant_log.delete();
        pop_log.delete();
    endtask

    task automatic check_out_log(input string name);
        check({name, "_len"}, 64'(out_log.size()), 64'(exp_out.size()));
        for (int i = 0; i < out_log.size() && i < exp_out.size(); i++) begin
            check($sformatf("%s[%0d]", name, i), 64'(out_log[i]), 64'(exp_out[i]));
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'b0000, 1'b0, 1'b0, 33'd0,            2'd0, 1'b0};
        vecs[1] = '{1'b1, 4'b0100, 1'b0, 1'b0, 33'd0,            2'd2, 1'b1};
        vecs[2] = '{1'b1, 4'b0100, 1'b1, 1'b1, 33'd25,           2'd2, 1'b1};
        vecs[3] = '{1'b1, 4'b0100, 1'b1, 1'b1, 33'd78,           2'd2, 1'b1};
        vecs[4] = '{1'b1, 4'b0000, 1'b1, 1'b1, {1'b1, 32'd738},  2'd2, 1'b0};
        vecs[5] = '{1'b1, 4'b0000, 1'b0, 1'b0, 33'd0,            2'd2, 1'b0};

        out_ready = 1'b1;
        refresh();
        run(2);
        rst = 1'b0;
        #1;
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_err_trunc", 64'(err_trunc), 64'd0);

        // Single 3-word packet on queue 2, checked cycle by cycle.
        clear_logs();
        qm[2].push_back(33'd25);
        qm[2].push_back(33'd78);
        qm[2].push_back({1'b1, 32'd738});
        refresh();
        #1;
        for (int i = 0; i < 6; i++) begin
            out_ready = vecs[i].ready;
            #1;
            check($sformatf("pkt_rd_en[%0d]", i), 64'(q_rd_en), 64'(vecs[i].rd_en));
            check($sformatf("pkt_valid[%0d]", i), 64'(out_valid), 64'(vecs[i].ov));
            if (vecs[i].chk_od)
                check($sformatf("pkt_data[%0d]", i), 64'(out_data), 64'(vecs[i].od));
            check($sformatf("pkt_grant[%0d]", i), 64'(grant), 64'(vecs[i].gnt));
            check($sformatf("pkt_busy[%0d]", i), 64'(busy), 64'(vecs[i].bsy));
            step();
        end
        exp_out = '{33'd25, 33'd78, {1'b1, 32'd738}};
        check_out_log("pkt_out");

        // Round-robin: 0 then 1 with one idle gap, then 2 before 0.
        clear_logs();
        qm[0].push_back({1'b1, 32'hA0});
        qm[1].push_back({1'b1, 32'hA1});
        refresh();
        #1;
        run(6);
        check("rr_grant_cnt", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2) begin
            check("rr_grant0", 64'(grant_log[0]), 64'd0);
            check("rr_grant1", 64'(grant_log[1]), 64'd1);
        end
        check("rr_pop_cnt", 64'(pop_log.size()), 64'd2);
        if (pop_log.size() == 2)
            check("rr_pop_gap", 64'(pop_log[1] - pop_log[0]), 64'd2);
        exp_out = '{{1'b1, 32'hA0}, {1'b1, 32'hA1}};
        check_out_log("rr_out");

        clear_logs();
        qm[0].push_back({1'b1, 32'hB0});
        qm[2].push_back({1'b1, 32'hB2});
        refresh();
        #1;
        run(6);
        check("rr2_grant_cnt", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2) begin
            check("rr2_grant0", 64'(grant_log[0]), 64'd2);
            check("rr2_grant1", 64'(grant_log[1]), 64'd0);
        end
        exp_out = '{{1'b1, 32'hB2}, {1'b1, 32'hB0}};
        check_out_log("rr2_out");

        // Backpressure: hold 4 cycles after the first word of queue 1.
        clear_logs();
        qm[1].push_back(33'd11);
        qm[1].push_back(33'd12);
        qm[1].push_back({1'b1, 32'd13});
        refresh();
        #1;
        run(2);
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_rd_en[%0d]", i), 64'(q_rd_en), 64'd0);
            check($sformatf("bp_valid[%0d]", i), 64'(out_valid), 64'd1);
            check($sformatf("bp_data[%0d]", i), 64'(out_data), 64'd11);
            step();
        end
        out_ready = 1'b1;
        #1;
        run(6);
        exp_out = '{33'd11, 33'd12, {1'b1, 32'd13}};
        check_out_log("bp_out");
        check("bp_q1_left", 64'(qm[1].size()), 64'd0);

        // Queue 3 underflows mid-packet while queue 0 waits.
        clear_logs();
        qm[3].push_back(33'd31);
        qm[0].push_back({1'b1, 32'd90});
        refresh();
        #1;
        run(2);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("uf_grant[%0d]", i), 64'(grant), 64'd3);
            check($sformatf("uf_busy[%0d]", i), 64'(busy), 64'd1);
            check($sformatf("uf_rd_en[%0d]", i), 64'(q_rd_en), 64'd0);
            step();
        end
        check("uf_q0_held", 64'(qm[0].size()), 64'd1);
        qm[3].push_back(33'd32);
        qm[3].push_back({1'b1, 32'd33});
        refresh();
        #1;
        run(10);
        exp_out = '{33'd31, 33'd32, {1'b1, 32'd33}, {1'b1, 32'd90}};
        check_out_log("uf_out");
        check("uf_grant_cnt", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2) begin
            check("uf_grant0", 64'(grant_log[0]), 64'd3);
            check("uf_grant1", 64'(grant_log[1]), 64'd0);
        end

        // Watchdog: 6-word packet without EOP, limit 4 words.
        clear_logs();
        for (int i = 0; i < 6; i++) qm[1].push_back(33'(41 + i));
        refresh();
        #1;
        for (int s = 1; s <= 5; s++) begin
            step();
            check($sformatf("wd_err[%0d]", s), 64'(err_trunc), (s == 5) ? 64'd1 : 64'd0);
        end
        check("wd_busy", 64'(busy), 64'd0);
        check("wd_q1_left", 64'(qm[1].size()), 64'd2);
        step();
        check("wd_err_pulse", 64'(err_trunc), 64'd0);
        check("wd_regrant_busy", 64'(busy), 64'd1);
        check("wd_regrant", 64'(grant), 64'd1);
        step();
        check("rst_pre_busy", 64'(busy), 64'd1);

        // Synchronous reset while a packet is in progress.
        rst = 1'b1;
        step();
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_rd_en", 64'(q_rd_en), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_grant", 64'(grant), 64'd0);
        check("rst_mid_data", 64'(out_data), 64'd0);
        rst = 1'b0;
        #1;
        clear_logs();
        qm[0].push_back({1'b1, 32'd70});
        qm[3].push_back({1'b1, 32'd73});
        refresh();
        #1;
        step();
        check("rst_ptr_grant", 64'(grant), 64'd0);
        run(6);
        exp_out = '{{1'b1, 32'd70}, {1'b1, 32'd73}};
        check_out_log("rst_out");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
